// File: rtl/ixu_writeback.sv
// ixu_writeback: result buffer between the IXU execute ALU and the integer register file.
// A small FIFO, Depth entries deep, absorbs register-file write stalls. The youngest buffered
// entry is exposed as a bypass so decode can forward operands that are not yet written back.
// Optional feature: define IXU_WB_PERF_CNT_EN to add the retire_cnt_o retired-op counter.
module ixu_writeback #(
  parameter int unsigned Depth = 2,  // 2 or 4 entries
  parameter int unsigned Xlen  = 32,
  parameter int unsigned RaW   = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,        // synchronous, active-low
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [Xlen-1:0] ex_result_i,
  input  logic [RaW-1:0]  ex_rd_i,
  input  logic            ex_is_nop_i,
  output logic            rf_we_o,
  input  logic            rf_ready_i,
  output logic [RaW-1:0]  rf_waddr_o,
  output logic [Xlen-1:0] rf_wdata_o,
  output logic            byp_valid_o,
  output logic [RaW-1:0]  byp_rd_o,
`ifdef IXU_WB_PERF_CNT_EN
  output logic [31:0]     retire_cnt_o,
`endif
  output logic [Xlen-1:0] byp_data_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [RaW-1:0]  rd_q   [Depth];
  logic [Xlen-1:0] data_q [Depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] young_ptr;
  logic [CntW-1:0] count_q, count_d;

  logic accept;
  logic push;
  logic pop;
  logic x0_retire;

  // Handshake and qualification; ex_ready depends only on registered count.
  always_comb begin
    ex_ready_o = (count_q < CntW'(Depth));
    rf_we_o    = (count_q != '0);
    accept     = ex_valid_i & ex_ready_o;
    // NOPs vanish; x0 writes are dropped but still count as retired work.
    push       = accept & ~ex_is_nop_i & (ex_rd_i != '0);
    x0_retire  = accept & ~ex_is_nop_i & (ex_rd_i == '0);
    pop        = rf_we_o & rf_ready_i;
  end

  // Read-side outputs: head feeds the register file, tail-1 feeds the bypass.
  always_comb begin
    young_ptr   = wr_ptr_q - PtrW'(1);
    rf_waddr_o  = rd_q[rd_ptr_q];
    rf_wdata_o  = data_q[rd_ptr_q];
    byp_valid_o = (count_q != '0);
    byp_rd_o    = rd_q[young_ptr];
    byp_data_o  = data_q[young_ptr];
  end

  // Pointer and occupancy next-state; pointers wrap naturally since Depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // FIFO state and storage; reset flushes every entry so nothing stale can be written.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        rd_q[wr_ptr_q]   <= ex_rd_i;
        data_q[wr_ptr_q] <= ex_result_i;
      end
    end
  end

`ifdef IXU_WB_PERF_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Retired ops: each register-file write plus each suppressed x0 write; wraps at 2^32.
  always_comb begin
    retire_cnt_d = retire_cnt_q + 32'(pop) + 32'(x0_retire);
  end

  // Retire counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
`else
  logic unused_x0_retire;
  assign unused_x0_retire = x0_retire;
`endif

endmodule

// File: tb/tb_ixu_writeback.sv
// Self-checking bench for ixu_writeback: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the write buffer.
module tb_ixu_writeback;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [4:0]  ex_rd;
  logic        ex_is_nop;
  logic        rf_we;
  logic        rf_ready;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
`ifdef IXU_WB_PERF_CNT_EN
  logic [31:0] retire_cnt;
`endif

  ixu_writeback #(
    .Depth (DEPTH),
    .Xlen  (32),
    .RaW   (5)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ex_valid_i   (ex_valid),
    .ex_ready_o   (ex_ready),
    .ex_result_i  (ex_result),
    .ex_rd_i      (ex_rd),
    .ex_is_nop_i  (ex_is_nop),
    .rf_we_o      (rf_we),
    .rf_ready_i   (rf_ready),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .byp_valid_o  (byp_valid),
    .byp_rd_o     (byp_rd),
`ifdef IXU_WB_PERF_CNT_EN
    .retire_cnt_o (retire_cnt),
`endif
    .byp_data_o   (byp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model: pending writes in program order, and the retired-op total.
  logic [36:0] model_q[$];
  logic [31:0] model_retired;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("ex_ready", 64'(ex_ready), 64'(model_q.size() < DEPTH));
    check("rf_we", 64'(rf_we), 64'(model_q.size() != 0));
    check("byp_valid", 64'(byp_valid), 64'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check("rf_waddr", 64'(rf_waddr), 64'(model_q[0][36:32]));
      check("rf_wdata", 64'(rf_wdata), 64'(model_q[0][31:0]));
      check("byp_rd", 64'(byp_rd), 64'(model_q[model_q.size()-1][36:32]));
      check("byp_data", 64'(byp_data), 64'(model_q[model_q.size()-1][31:0]));
    end
`ifdef IXU_WB_PERF_CNT_EN
    check("retire_cnt", 64'(retire_cnt), 64'(model_retired));
`endif
  endtask

  // One clock: drive inputs, advance the model by the rules, then sample at the falling edge.
  task automatic step(input bit v, input logic [4:0] rd, input logic [31:0] d, input bit nop,
                      input bit rr, input bit rst);
    bit room;
    bit drain;
    rst_n     = ~rst;
    ex_valid  = v;
    ex_rd     = rd;
    ex_result = d;
    ex_is_nop = nop;
    rf_ready  = rr;
    if (rst) begin
      model_q.delete();
      model_retired = '0;
    end else begin
      room  = model_q.size() < DEPTH;
      drain = (model_q.size() != 0) && rr;
      if (drain) begin
        void'(model_q.pop_front());
        model_retired++;
      end
      if (v && room && !nop) begin
        if (rd == 5'd0) model_retired++;
        else model_q.push_back({rd, d});
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_retired = '0;
    rst_n = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_result = '0; ex_is_nop = 1'b0;
    rf_ready = 1'b0;
    @(negedge clk);

    // Reset state.
    step(0, 0, 0, 0, 0, 1);
    check("reset_ex_ready", 64'(ex_ready), 64'd1);
    check("reset_rf_we", 64'(rf_we), 64'd0);

    // Single op with register file ready: visible one cycle later, gone the cycle after.
    step(1, 5, 32'h7, 0, 1, 0);
    check("t1_rf_we", 64'(rf_we), 64'd1);
    check("t1_waddr", 64'(rf_waddr), 64'd5);
    check("t1_wdata", 64'(rf_wdata), 64'd7);
    check("t1_byp_rd", 64'(byp_rd), 64'd5);
    step(0, 0, 0, 0, 1, 0);
    check("t1_drained", 64'(rf_we), 64'd0);

    // Fill under stall, hold a third op, then drain in order.
    step(1, 1, 32'hA, 0, 0, 0);
    step(1, 2, 32'hB, 0, 0, 0);
    check("t2_full", 64'(ex_ready), 64'd0);
    check("t2_byp_rd", 64'(byp_rd), 64'd2);
    check("t2_byp_data", 64'(byp_data), 64'hB);
    step(1, 3, 32'hC, 0, 0, 0);
    check("t2_held_head", 64'(rf_waddr), 64'd1);
    step(1, 3, 32'hC, 0, 1, 0);
    check("t2_second", 64'(rf_waddr), 64'd2);
    check("t2_ready_again", 64'(ex_ready), 64'd1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("t2_empty", 64'(rf_we), 64'd0);

    // NOP and x0 write: neither ever reaches the register file.
    step(1, 3, 32'h1234, 1, 1, 0);
    check("t3_nop", 64'(rf_we), 64'd0);
    step(1, 0, 32'hDEADBEEF, 0, 1, 0);
    check("t3_x0", 64'(rf_we), 64'd0);

    // Back-to-back stream with simultaneous push/pop, covering pointer wrap.
    for (int i = 0; i < 8; i++) begin
      step(1, 5'(i + 8), 32'h100 + 32'(i), 0, 1, 0);
      check("t4_stream_we", 64'(rf_we), 64'd1);
    end
    step(0, 0, 0, 0, 1, 0);

    // Reset while full discards everything.
    step(1, 9, 32'h99, 0, 0, 0);
    step(1, 10, 32'h98, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("t5_rf_we", 64'(rf_we), 64'd0);
    check("t5_byp", 64'(byp_valid), 64'd0);
    check("t5_ready", 64'(ex_ready), 64'd1);
    step(0, 0, 0, 0, 1, 0);
    check("t5_no_stale", 64'(rf_we), 64'd0);

`ifdef IXU_WB_PERF_CNT_EN
    // Counter wrap: preload to all ones, then one pop.
    step(1, 4, 32'h44, 0, 0, 0);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    model_retired = 32'hFFFF_FFFF;
    step(0, 0, 0, 0, 1, 0);
    check("t6_wrap", 64'(retire_cnt), 64'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) < 3),
           ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
